core_sequencer: RTL and testbench

//  Multi-cycle control FSM for the RV32I core: fetch, decode, execute, memory, writeback.

---
 rtl/core_sequencer_pkg.sv | 49 ++++
 rtl/core_sequencer_if.sv | 39 +++
 rtl/core_sequencer_bus_watchdog.sv | 28 ++
 rtl/core_sequencer.sv | 123 ++++++++++++
 tb/tb_core_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_sequencer_pkg.sv
// Shared types for the RV32I multi-cycle sequencer: state/trap encodings, opcode map and classifier.
package core_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE, FETCH, IWAIT, DECODE, EXEC, MEM, DWAIT, WB, HALT, TRAP
    } seq_state_e;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'b00,
        TRAP_ILLEGAL = 2'b01,
        TRAP_ECALL   = 2'b10,
        TRAP_BUS     = 2'b11
    } trap_cause_e;

    typedef enum logic [1:0] {
        CLS_EXEC, CLS_MEM, CLS_SYSTEM, CLS_ILLEGAL
    } op_class_e;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OP_LUI    = 7'b0110111;
    localparam opcode_t OP_AUIPC  = 7'b0010111;
    localparam opcode_t OP_JAL    = 7'b1101111;
    localparam opcode_t OP_JALR   = 7'b1100111;
    localparam opcode_t OP_BRANCH = 7'b1100011;
    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_ALUI   = 7'b0010011;
    localparam opcode_t OP_ALU    = 7'b0110011;
    localparam opcode_t OP_FENCE  = 7'b0001111;
    localparam opcode_t OP_SYSTEM = 7'b1110011;

    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int CNT_WIDTH_DEF   = 32;

    localparam logic [1:0] RES_LOAD = 2'b10;

    // FENCE has no side effects on a single in-order core, so it retires like an ALU op.
    function automatic op_class_e classify(input opcode_t op);
        case (op)
            OP_LOAD, OP_STORE: return CLS_MEM;
            OP_SYSTEM:         return CLS_SYSTEM;
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_ALU, OP_ALUI, OP_FENCE: return CLS_EXEC;
            default:           return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Sequencer <-> datapath/memory control bundle; master = sequencer, slave = memories + decoder + datapath.
interface core_sequencer_if #(
    parameter int CNT_WIDTH = 32
);
    logic                        halt_i;
    logic                        imem_req_o;
    logic                        imem_gnt_i;
    logic                        imem_rvalid_i;
    logic                        ir_we_o;
    core_sequencer_pkg::opcode_t opcode_i;
    logic                        reg_write_i;
    logic                        mem_write_i;
    logic [1:0]                  result_mux_i;
    logic                        dmem_req_o;
    logic                        dmem_we_o;
    logic                        dmem_gnt_i;
    logic                        dmem_rvalid_i;
    logic                        rf_we_o;
    logic                        pc_we_o;
    logic                        halted_o;
    logic                        trap_o;
    logic [1:0]                  trap_cause_o;
    logic [CNT_WIDTH-1:0]        instret_o;

    modport master (
        input  halt_i, imem_gnt_i, imem_rvalid_i, opcode_i, reg_write_i, mem_write_i,
               result_mux_i, dmem_gnt_i, dmem_rvalid_i,
        output imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o,
               halted_o, trap_o, trap_cause_o, instret_o
    );

    modport slave (
        output halt_i, imem_gnt_i, imem_rvalid_i, opcode_i, reg_write_i, mem_write_i,
               result_mux_i, dmem_gnt_i, dmem_rvalid_i,
        input  imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o,
               halted_o, trap_o, trap_cause_o, instret_o
    );

endinterface

// File: rtl/core_sequencer_bus_watchdog.sv
// Counts cycles spent waiting on a bus handshake; expired is high on the last permitted wait cycle.
// Zero latency on expired (decode of the count register); clear has priority over counting.
module bus_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT) + 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb with bus watchdog, traps, halt and instret.
// Waits indefinitely-but-bounded on gnt/rvalid; outputs are state decodes, only ir_we follows rvalid directly.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input logic              clk_i,
    input logic              rst_ni,
    core_sequencer_if.master bus
);

    seq_state_e           state, state_d;
    trap_cause_e          cause, cause_d;
    logic [CNT_WIDTH-1:0] instret;
    logic                 wd_clear, wd_en, wd_expired;

    bus_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    assign wd_en    = (state == FETCH) || (state == IWAIT) || (state == MEM) || (state == DWAIT);
    assign wd_clear = (state_d != state);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cause   <= TRAP_NONE;
            instret <= '0;
        end else begin
            state <= state_d;
            cause <= cause_d;
            if (state == WB) begin
                instret <= instret + 1'b1;
            end
        end
    end

    // A handshake landing on the final watchdog cycle still wins over the timeout.
    always_comb begin
        state_d = state;
        cause_d = cause;
        unique case (state)
            IDLE:   state_d = FETCH;
            FETCH: begin
                if (bus.imem_gnt_i) begin
                    state_d = IWAIT;
                end else if (wd_expired) begin
                    state_d = TRAP;
                    cause_d = TRAP_BUS;
                end
            end
            IWAIT: begin
                if (bus.imem_rvalid_i) begin
                    state_d = DECODE;
                end else if (wd_expired) begin
                    state_d = TRAP;
                    cause_d = TRAP_BUS;
                end
            end
            DECODE: begin
                unique case (classify(bus.opcode_i))
                    CLS_MEM:    state_d = MEM;
                    CLS_EXEC:   state_d = EXEC;
                    CLS_SYSTEM: begin
                        state_d = TRAP;
                        cause_d = TRAP_ECALL;
                    end
                    default: begin
                        state_d = TRAP;
                        cause_d = TRAP_ILLEGAL;
                    end
                endcase
            end
            EXEC:   state_d = WB;
            MEM: begin
                if (bus.dmem_gnt_i) begin
                    state_d = DWAIT;
                end else if (wd_expired) begin
                    state_d = TRAP;
                    cause_d = TRAP_BUS;
                end
            end
            DWAIT: begin
                if (bus.dmem_rvalid_i) begin
                    state_d = WB;
                end else if (wd_expired) begin
                    state_d = TRAP;
                    cause_d = TRAP_BUS;
                end
            end
            WB:     state_d = bus.halt_i ? HALT : FETCH;
            HALT: begin
                if (!bus.halt_i) begin
                    state_d = FETCH;
                end
            end
            TRAP:   state_d = TRAP;
            default: begin
                state_d = IDLE;
                cause_d = TRAP_NONE;
            end
        endcase
    end

    // A load never writes memory, even if the decoder raises mem_write alongside it.
    assign bus.imem_req_o   = (state == FETCH);
    assign bus.ir_we_o      = (state == IWAIT) && bus.imem_rvalid_i;
    assign bus.dmem_req_o   = (state == MEM);
    assign bus.dmem_we_o    = (state == MEM) && bus.mem_write_i && (bus.result_mux_i != RES_LOAD);
    assign bus.rf_we_o      = (state == WB) && bus.reg_write_i;
    assign bus.pc_we_o      = (state == WB);
    assign bus.halted_o     = (state == HALT);
    assign bus.trap_o       = (state == TRAP);
    assign bus.trap_cause_o = cause;
    assign bus.instret_o    = instret;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench: reactive memory responders plus a cycle-count model of the instruction timeline.
module tb_core_sequencer;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] ALUI   = 7'b0010011;
    localparam logic [6:0] ALU    = 7'b0110011;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam int NEVER = 1000;

    logic clk;
    logic rst_n;
    int checks;
    int errors;
    logic [31:0] exp_ret;

    core_sequencer_if #(.CNT_WIDTH(32)) bus ();

    core_sequencer #(.MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 0 = retires via EXEC, 1 = memory access, 2 = system trap, 3 = illegal
    function automatic int op_kind(input logic [6:0] op);
        logic [6:0] exec_ops [8];
        exec_ops = '{LUI, AUIPC, JAL, JALR, BRANCH, ALU, ALUI, FENCE};
        if (op == LOAD || op == STORE) return 1;
        if (op == SYSTEM) return 2;
        foreach (exec_ops[i]) if (exec_ops[i] == op) return 0;
        return 3;
    endfunction

    // Cycle (relative to first FETCH cycle) at which WB or TRAP is visible.
    function automatic int exp_end(input int kind, input int gi, input int ri, input int gd, input int rd);
        if (kind == 0) return gi + ri + 4;
        if (kind == 1) return gi + ri + gd + rd + 5;
        return gi + ri + 3;
    endfunction

    task automatic clear_handshakes();
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_handshakes();
        bus.halt_i       = 1'b0;
        bus.opcode_i     = 7'd0;
        bus.reg_write_i  = 1'b0;
        bus.mem_write_i  = 1'b0;
        bus.result_mux_i = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_ret = 32'd0;
    endtask

    // Plays memory for one instruction: gnt after gi/gd wait cycles, rvalid after ri/rd cycles.
    task automatic run_instr(input logic [6:0] op, input bit rw, input bit mw,
                             input int gi, input int ri, input int gd, input int rd, input bit halt_dw,
                             output int t_ir, output int n_ir, output int t_end, output int n_rf,
                             output int n_pc, output bit we_ok, output bit trapped, output logic [31:0] ret);
        int t, w, fc, ic, dc, rc, ph, nxt;
        bit done, is_mem;
        t_ir = -1; n_ir = 0; t_end = -1; n_rf = 0; n_pc = 0; we_ok = 1'b1; trapped = 1'b0;
        t = 0; w = 0; fc = 0; ic = 0; dc = 0; rc = 0; ph = 0; done = 1'b0;
        is_mem = (op_kind(op) == 1);
        while (bus.imem_req_o !== 1'b1 && w < 40) begin
            @(negedge clk); #1; w++;
        end
        bus.opcode_i     = op;
        bus.reg_write_i  = rw;
        bus.mem_write_i  = mw;
        bus.result_mux_i = (op == LOAD) ? 2'b10 : 2'b00;
        while (!done && t < 300) begin
            clear_handshakes();
            nxt = ph;
            case (ph)
                0: if (bus.imem_req_o === 1'b1) begin
                    if (fc == gi) begin bus.imem_gnt_i = 1'b1; nxt = 1; end
                    else if ($urandom_range(0, 2) == 0) bus.imem_rvalid_i = 1'b1;
                    fc++;
                end
                1: begin
                    if (ic == ri) begin bus.imem_rvalid_i = 1'b1; nxt = 2; end
                    ic++;
                end
                2: if (bus.dmem_req_o === 1'b1) begin
                    if (!is_mem || bus.dmem_we_o !== mw) we_ok = 1'b0;
                    if (dc == gd) begin bus.dmem_gnt_i = 1'b1; nxt = 3; end
                    else if ($urandom_range(0, 2) == 0) bus.dmem_rvalid_i = 1'b1;
                    dc++;
                end
                default: begin
                    if (halt_dw) bus.halt_i = 1'b1;
                    if (rc == rd) begin bus.dmem_rvalid_i = 1'b1; nxt = 4; end
                    rc++;
                end
            endcase
            #1;
            if (bus.ir_we_o === 1'b1) begin t_ir = t; n_ir++; end
            if (bus.rf_we_o === 1'b1) n_rf++;
            if (bus.pc_we_o === 1'b1) begin n_pc++; t_end = t; done = 1'b1; end
            if (bus.trap_o === 1'b1) begin trapped = 1'b1; t_end = t; done = 1'b1; end
            ph = nxt;
            if (!done) begin
                @(negedge clk); #1; t++;
            end
        end
        clear_handshakes();
        @(negedge clk); #1;
        ret = bus.instret_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_handshakes();
        bus.imem_rvalid_i = 1'b1;
        bus.dmem_gnt_i    = 1'b1;
        bus.halt_i        = 1'b0;
        bus.reg_write_i   = 1'b1;
        #1;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_imem_req got %b want 0", bus.imem_req_o); end
        checks++; if (bus.ir_we_o !== 1'b0) begin errors++; $display("FAIL rst_ir_we got %b want 0", bus.ir_we_o); end
        checks++; if (bus.dmem_req_o !== 1'b0 || bus.dmem_we_o !== 1'b0) begin errors++; $display("FAIL rst_dmem got %b%b want 00", bus.dmem_req_o, bus.dmem_we_o); end
        checks++; if (bus.rf_we_o !== 1'b0 || bus.pc_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got %b%b want 00", bus.rf_we_o, bus.pc_we_o); end
        checks++; if (bus.halted_o !== 1'b0 || bus.trap_o !== 1'b0) begin errors++; $display("FAIL rst_status got %b%b want 00", bus.halted_o, bus.trap_o); end
        checks++; if (bus.trap_cause_o !== 2'b00) begin errors++; $display("FAIL rst_cause got %b want 00", bus.trap_cause_o); end
        checks++; if (bus.instret_o !== 32'd0) begin errors++; $display("FAIL rst_instret got %0d want 0", bus.instret_o); end
        do_reset();
        @(negedge clk); #1;
        checks++; if (bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL idle_to_fetch got %b want 1", bus.imem_req_o); end
    endtask

    task automatic test_addi();
        int t_ir, n_ir, t_end, n_rf, n_pc; bit we_ok, tr; logic [31:0] ret;
        do_reset();
        run_instr(ALUI, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, t_ir, n_ir, t_end, n_rf, n_pc, we_ok, tr, ret);
        exp_ret++;
        checks++; if (t_ir !== 1) begin errors++; $display("FAIL addi_ir_we_cycle got %0d want 1", t_ir); end
        checks++; if (t_end !== 4) begin errors++; $display("FAIL addi_wb_cycle got %0d want 4", t_end); end
        checks++; if (n_rf !== 1 || n_pc !== 1) begin errors++; $display("FAIL addi_pulses got rf=%0d pc=%0d want 1 1", n_rf, n_pc); end
        checks++; if (ret !== exp_ret) begin errors++; $display("FAIL addi_instret got %0d want %0d", ret, exp_ret); end
    endtask

    task automatic test_store();
        int t_ir, n_ir, t_end, n_rf, n_pc; bit we_ok, tr; logic [31:0] ret;
        run_instr(STORE, 1'b0, 1'b1, 0, 0, 3, 0, 1'b0, t_ir, n_ir, t_end, n_rf, n_pc, we_ok, tr, ret);
        exp_ret++;
        checks++; if (we_ok !== 1'b1) begin errors++; $display("FAIL sw_dmem_we got %b want 1", we_ok); end
        checks++; if (t_end !== exp_end(1, 0, 0, 3, 0)) begin errors++; $display("FAIL sw_wb_cycle got %0d want %0d", t_end, exp_end(1, 0, 0, 3, 0)); end
        checks++; if (n_rf !== 0 || n_pc !== 1) begin errors++; $display("FAIL sw_pulses got rf=%0d pc=%0d want 0 1", n_rf, n_pc); end
        checks++; if (ret !== exp_ret) begin errors++; $display("FAIL sw_instret got %0d want %0d", ret, exp_ret); end
    endtask

    task automatic test_back_to_back();
        int t_ir, n_ir, t_end, n_rf, n_pc; bit we_ok, tr; logic [31:0] ret;
        do_reset();
        run_instr(LOAD, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, t_ir, n_ir, t_end, n_rf, n_pc, we_ok, tr, ret);
        exp_ret++;
        checks++; if (n_rf !== 1 || t_end !== 5) begin errors++; $display("FAIL lw_wb got rf=%0d t=%0d want 1 5", n_rf, t_end); end
        run_instr(ALU, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, t_ir, n_ir, t_end, n_rf, n_pc, we_ok, tr, ret);
        exp_ret++;
        checks++; if (n_rf !== 1 || t_end !== 4) begin errors++; $display("FAIL add_wb got rf=%0d t=%0d want 1 4", n_rf, t_end); end
        checks++; if (ret !== 32'd2) begin errors++; $display("FAIL b2b_instret got %0d want 2", ret); end
    endtask

    task automatic test_random();
        logic [6:0] pool [10];
        int t_ir, n_ir, t_end, n_rf, n_pc, gi, ri, gd, rd, k; bit we_ok, tr, rw, mw; logic [31:0] ret;
        logic [6:0] op;
        pool = '{LUI, AUIPC, JAL, JALR, BRANCH, ALU, ALUI, FENCE, LOAD, STORE};
        for (int n = 0; n < 24; n++) begin
            op = pool[$urandom_range(0, 9)];
            rw = !(op == STORE || op == BRANCH || op == FENCE);
            mw = (op == STORE);
            gi = $urandom_range(0, 4); ri = $urandom_range(0, 4);
            gd = $urandom_range(0, 4); rd = $urandom_range(0, 4);
            k  = op_kind(op);
            run_instr(op, rw, mw, gi, ri, gd, rd, 1'b0, t_ir, n_ir, t_end, n_rf, n_pc, we_ok, tr, ret);
            exp_ret++;
            checks++; if (t_ir !== gi + 1 + ri || n_ir !== 1) begin errors++; $display("FAIL rnd%0d_ir got t=%0d n=%0d want %0d 1", n, t_ir, n_ir, gi + 1 + ri); end
            checks++; if (t_end !== exp_end(k, gi, ri, gd, rd)) begin errors++; $display("FAIL rnd%0d_wb_cycle op=%b got %0d want %0d", n, op, t_end, exp_end(k, gi, ri, gd, rd)); end
            checks++; if (n_rf !== int'(rw) || n_pc !== 1) begin errors++; $display("FAIL rnd%0d_pulses got rf=%0d pc=%0d want %0d 1", n, n_rf, n_pc, rw); end
            checks++; if (we_ok !== 1'b1 || tr !== 1'b0) begin errors++; $display("FAIL rnd%0d_dmem_trap got we_ok=%b trap=%b want 1 0", n, we_ok, tr); end
            checks++; if (ret !== exp_ret) begin errors++; $display("FAIL rnd%0d_instret got %0d want %0d", n, ret, exp_ret); end
        end
    endtask

    task automatic test_traps();
        int t_ir, n_ir, t_end, n_rf, n_pc; bit we_ok, tr, bad; logic [31:0] ret;
        do_reset();
        run_instr(7'b1111111, 1'b1, 1'b0, 1, 2, 0, 0, 1'b0, t_ir, n_ir, t_end, n_rf, n_pc, we_ok, tr, ret);
        checks++; if (tr !== 1'b1 || t_end !== exp_end(3, 1, 2, 0, 0)) begin errors++; $display("FAIL illegal_trap got trap=%b t=%0d want 1 %0d", tr, t_end, exp_end(3, 1, 2, 0, 0)); end
        checks++; if (bus.trap_cause_o !== 2'b01) begin errors++; $display("FAIL illegal_cause got %b want 01", bus.trap_cause_o); end
        checks++; if (n_pc !== 0 || n_rf !== 0 || ret !== 32'd0) begin errors++; $display("FAIL illegal_no_retire got pc=%0d rf=%0d ret=%0d want 0 0 0", n_pc, n_rf, ret); end
        bad = 1'b0;
        bus.halt_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.trap_o !== 1'b1 || bus.pc_we_o !== 1'b0 || bus.rf_we_o !== 1'b0 || bus.imem_req_o !== 1'b0 || bus.trap_cause_o !== 2'b01) bad = 1'b1;
            @(negedge clk); #1;
        end
        bus.halt_i = 1'b0;
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL trap_sticky got bad=%b want 0", bad); end
        do_reset();
        run_instr(SYSTEM, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, t_ir, n_ir, t_end, n_rf, n_pc, we_ok, tr, ret);
        checks++; if (tr !== 1'b1 || bus.trap_cause_o !== 2'b10) begin errors++; $display("FAIL ecall_cause got trap=%b cause=%b want 1 10", tr, bus.trap_cause_o); end
        checks++; if (n_pc !== 0) begin errors++; $display("FAIL ecall_no_pc got %0d want 0", n_pc); end
    endtask

    task automatic test_timeout();
        int t_ir, n_ir, t_end, n_rf, n_pc; bit we_ok, tr; logic [31:0] ret;
        do_reset();
        run_instr(ALU, 1'b1, 1'b0, NEVER, 0, 0, 0, 1'b0, t_ir, n_ir, t_end, n_rf, n_pc, we_ok, tr, ret);
        checks++; if (tr !== 1'b1 || t_end !== 16) begin errors++; $display("FAIL fetch_timeout got trap=%b t=%0d want 1 16", tr, t_end); end
        checks++; if (bus.trap_cause_o !== 2'b11 || bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL fetch_timeout_state got cause=%b req=%b want 11 0", bus.trap_cause_o, bus.imem_req_o); end
        do_reset();
        run_instr(ALU, 1'b1, 1'b0, 15, 15, 0, 0, 1'b0, t_ir, n_ir, t_end, n_rf, n_pc, we_ok, tr, ret);
        checks++; if (tr !== 1'b0 || t_end !== exp_end(0, 15, 15, 0, 0)) begin errors++; $display("FAIL last_cycle_gnt got trap=%b t=%0d want 0 %0d", tr, t_end, exp_end(0, 15, 15, 0, 0)); end
        do_reset();
        run_instr(LOAD, 1'b1, 1'b0, 0, 0, 1, NEVER, 1'b0, t_ir, n_ir, t_end, n_rf, n_pc, we_ok, tr, ret);
        checks++; if (tr !== 1'b1 || t_end !== 5 + 16) begin errors++; $display("FAIL dwait_timeout got trap=%b t=%0d want 1 21", tr, t_end); end
        checks++; if (bus.trap_cause_o !== 2'b11 || bus.dmem_req_o !== 1'b0 || n_rf !== 0) begin errors++; $display("FAIL dwait_timeout_state got cause=%b req=%b rf=%0d want 11 0 0", bus.trap_cause_o, bus.dmem_req_o, n_rf); end
    endtask

    task automatic test_halt();
        int t_ir, n_ir, t_end, n_rf, n_pc; bit we_ok, tr, bad; logic [31:0] ret;
        do_reset();
        run_instr(LOAD, 1'b1, 1'b0, 0, 0, 1, 2, 1'b1, t_ir, n_ir, t_end, n_rf, n_pc, we_ok, tr, ret);
        checks++; if (t_end !== exp_end(1, 0, 0, 1, 2) || n_rf !== 1) begin errors++; $display("FAIL halt_access_done got t=%0d rf=%0d want %0d 1", t_end, n_rf, exp_end(1, 0, 0, 1, 2)); end
        checks++; if (bus.halted_o !== 1'b1 || bus.imem_req_o !== 1'b0 || ret !== 32'd1) begin errors++; $display("FAIL halt_entry got halted=%b req=%b ret=%0d want 1 0 1", bus.halted_o, bus.imem_req_o, ret); end
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (bus.halted_o !== 1'b1 || bus.imem_req_o !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL halt_hold got bad=%b want 0", bad); end
        bus.halt_i = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.halted_o !== 1'b0) begin errors++; $display("FAIL halt_resume got req=%b halted=%b want 1 0", bus.imem_req_o, bus.halted_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.imem_req_o !== 1'b0 || bus.instret_o !== 32'd0) begin errors++; $display("FAIL async_reset got req=%b instret=%0d want 0 0", bus.imem_req_o, bus.instret_o); end
        do_reset();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_ret = 32'd0;
        rst_n = 1'b0;
        bus.halt_i       = 1'b0;
        bus.opcode_i     = 7'd0;
        bus.reg_write_i  = 1'b0;
        bus.mem_write_i  = 1'b0;
        bus.result_mux_i = 2'b00;
        clear_handshakes();
        test_reset();
        test_addi();
        test_store();
        test_back_to_back();
        do_reset();
        test_random();
        test_traps();
        test_timeout();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
